// File: rtl/enemy_shot_if.sv
// Enemy projectile bus between the invader block (master) and the hit detector (slave).
interface enemy_shot_if;
  logic [45:0] enemy_projectiles_x;
  logic [44:0] enemy_projectiles_y;
  logic [4:0]  destroy;

  modport master (output enemy_projectiles_x, enemy_projectiles_y, input destroy);
  modport slave  (input enemy_projectiles_x, enemy_projectiles_y, output destroy);
endinterface

// File: rtl/enemy_shot_hit_detector.sv
// Tests the 5 enemy shots against the player hitbox, pulses destroy, manages lives/invuln/game-over.
// Optional sprite blink during invulnerability: define PLAYER_BLINK_EN.
module enemy_shot_hit_detector #(
  parameter int START_LIVES  = 3,
  parameter int HIT_HALF_W   = 8,
  parameter int HIT_H        = 16,
  parameter int INVULN_TICKS = 120,
  parameter int BLINK_TICKS  = 8
) (
  input  logic       clk_4_i,
  input  logic       clr_i,
  input  logic       play_i,
  input  logic [9:0] player_x_i,
  input  logic [9:0] player_y_i,
  enemy_shot_if.slave shot_bus,
  output logic       player_hit_o,
  output logic [3:0] lives_o,
  output logic       invulnerable_o,
  output logic       game_over_o,
  output logic       player_visible_o
);
  localparam int CW = $clog2(INVULN_TICKS);
  localparam logic [CW-1:0] CNT_INIT = CW'(INVULN_TICKS - 1);
  localparam logic signed [10:0] HW_S = 11'(HIT_HALF_W);
  localparam logic signed [10:0] HH_S = 11'(HIT_H);

  if (START_LIVES < 1 || START_LIVES > 15 || INVULN_TICKS < 2 || BLINK_TICKS < 1) begin : g_bad_param
    $error("enemy_shot_hit_detector: parameter out of range");
  end

  typedef enum logic [1:0] {S_ALIVE, S_INVULN, S_DEAD} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    lives_q, lives_d;
  logic          hit_q, hit_d;
  logic [4:0]    destroy_q, destroy_d;
  logic [4:0]    hit;

  logic signed [10:0] px, py;
  assign px = {1'b0, player_x_i};
  assign py = {1'b0, player_y_i};

  // Operands zero-extended into 11-bit signed, so py-HIT_H going negative acts as a clamp at 0.
  for (genvar g = 0; g < 5; g++) begin : g_lane
    localparam int XW = (g == 4) ? 10 : 9;
    logic signed [10:0] ex, ey, dx, adx;
    assign ex  = {{(11-XW){1'b0}}, shot_bus.enemy_projectiles_x[9*g +: XW]};
    assign ey  = {2'b00, shot_bus.enemy_projectiles_y[9*g +: 9]};
    assign dx  = ex - px;
    assign adx = dx[10] ? -dx : dx;
    assign hit[g] = (ey != 11'sd0) && (adx <= HW_S) && (ey >= py - HH_S) && (ey <= py);
  end

  always_comb begin
    // destroy_q doubles as the mask: the invader clears the lane on the edge that samples it
    destroy_d = (state_q == S_DEAD) ? 5'd0 : (hit & ~destroy_q);
    state_d   = state_q;
    cnt_d     = cnt_q;
    lives_d   = lives_q;
    hit_d     = 1'b0;
    case (state_q)
      S_ALIVE: begin
        if (|destroy_d) begin
          hit_d   = 1'b1;
          lives_d = (lives_q == 4'd0) ? 4'd0 : lives_q - 4'd1;
          cnt_d   = CNT_INIT;
          state_d = (lives_q <= 4'd1) ? S_DEAD : S_INVULN;
        end
      end
      S_INVULN: begin
        if (cnt_q == '0) state_d = S_ALIVE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_DEAD:  lives_d = 4'd0;
      default: state_d = S_ALIVE;
    endcase
  end

  always_ff @(posedge clk_4_i) begin
    if (clr_i || !play_i) begin
      state_q   <= S_ALIVE;
      cnt_q     <= '0;
      lives_q   <= 4'(START_LIVES);
      hit_q     <= 1'b0;
      destroy_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lives_q   <= lives_d;
      hit_q     <= hit_d;
      destroy_q <= destroy_d;
    end
  end

  assign shot_bus.destroy = destroy_q;
  assign player_hit_o     = hit_q;
  assign lives_o          = lives_q;
  assign invulnerable_o   = (state_q == S_INVULN);
  assign game_over_o      = (state_q == S_DEAD);

`ifdef PLAYER_BLINK_EN
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  logic [BW-1:0] blink_q, blink_d;
  logic          vis_q, vis_d;

  always_comb begin
    blink_d = blink_q;
    vis_d   = vis_q;
    case (state_d)
      S_ALIVE: vis_d = 1'b1;
      S_DEAD:  vis_d = 1'b0;
      S_INVULN: begin
        if (state_q != S_INVULN || blink_q == '0) begin
          vis_d   = (state_q == S_INVULN) ? ~vis_q : 1'b0;
          blink_d = BW'(BLINK_TICKS - 1);
        end else begin
          blink_d = blink_q - 1'b1;
        end
      end
      default: vis_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_4_i) begin
    if (clr_i || !play_i) begin
      blink_q <= '0;
      vis_q   <= 1'b1;
    end else begin
      blink_q <= blink_d;
      vis_q   <= vis_d;
    end
  end

  assign player_visible_o = vis_q;
`else
  assign player_visible_o = 1'b1;
`endif
endmodule

// File: tb/tb_enemy_shot_hit_detector.sv
// Randomized + directed bench for enemy_shot_hit_detector against an integer-level game model.
`timescale 1ns/1ps
module tb_enemy_shot_hit_detector;
  localparam int START = 3;
  localparam int HALFW = 8;
  localparam int HH    = 16;
  localparam int INV   = 120;
  localparam int BLINK = 8;

  logic       clk = 1'b0;
  logic       clr = 1'b1, play = 1'b1;
  logic [9:0] player_x, player_y;
  logic       player_hit, invulnerable, game_over, player_visible;
  logic [3:0] lives;

  enemy_shot_if bus();

  enemy_shot_hit_detector #(
    .START_LIVES(START), .HIT_HALF_W(HALFW), .HIT_H(HH),
    .INVULN_TICKS(INV), .BLINK_TICKS(BLINK)
  ) dut (
    .clk_4_i(clk), .clr_i(clr), .play_i(play),
    .player_x_i(player_x), .player_y_i(player_y),
    .shot_bus(bus.slave),
    .player_hit_o(player_hit), .lives_o(lives), .invulnerable_o(invulnerable),
    .game_over_o(game_over), .player_visible_o(player_visible)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit chk_en = 1'b0;
  int px, py;
  int ex[5], ey[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    player_x = 10'(px);
    player_y = 10'(py);
    for (int i = 0; i < 4; i++) begin
      bus.enemy_projectiles_x[9*i +: 9] = 9'(ex[i]);
      bus.enemy_projectiles_y[9*i +: 9] = 9'(ey[i]);
    end
    bus.enemy_projectiles_x[45:36] = 10'(ex[4]);
    bus.enemy_projectiles_y[44:36] = 9'(ey[4]);
  endtask

  task automatic cyc();
    drive();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < 5; i++) begin ex[i] = 0; ey[i] = 0; end
  endtask

  task automatic set_lane(input int i, input int x, input int y);
    ex[i] = x; ey[i] = y;
  endtask

  // ---------------- behavioural model ----------------
  int         m_lives = START;
  int         m_inv   = 0;      // remaining invulnerable cycles; 0 = not invulnerable
  bit         m_dead  = 1'b0;
  bit         m_hit   = 1'b0;
  logic [4:0] m_destroy = '0;
  logic [4:0] m_nd;

  function automatic bit in_box(input int x, input int y, input int cx, input int cy);
    return (y != 0) && (x - cx <= HALFW) && (cx - x <= HALFW) && (y >= cy - HH) && (y <= cy);
  endfunction

  always @(posedge clk) begin
    if (clr || !play) begin
      m_lives = START; m_inv = 0; m_dead = 1'b0; m_hit = 1'b0; m_destroy = '0;
    end else begin
      for (int i = 0; i < 5; i++)
        m_nd[i] = !m_dead && in_box(ex[i], ey[i], px, py) && !m_destroy[i];
      m_hit = 1'b0;
      if (!m_dead) begin
        if (m_inv > 0) m_inv--;
        else if (m_nd != 0) begin
          m_hit = 1'b1;
          m_lives--;
          if (m_lives == 0) m_dead = 1'b1;
          else              m_inv  = INV;
        end
      end
      m_destroy = m_nd;
    end
  end

  function automatic bit exp_vis();
`ifdef PLAYER_BLINK_EN
    if (m_dead)     return 1'b0;
    if (m_inv == 0) return 1'b1;
    return 1'(((INV - m_inv) / BLINK) % 2);
`else
    return 1'b1;
`endif
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_destroy", 32'(bus.destroy), 32'(m_destroy));
      chk("m_player_hit", 32'(player_hit), 32'(m_hit));
      chk("m_lives", 32'(lives), 32'(m_lives));
      chk("m_invulnerable", 32'(invulnerable), 32'(m_inv > 0));
      chk("m_game_over", 32'(game_over), 32'(m_dead));
      chk("m_visible", 32'(player_visible), 32'(exp_vis()));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  task automatic restart();
    play = 1'b0; cyc(); play = 1'b1;
  endtask

  initial begin
    px = 200; py = 400;
    clear_lanes();
    cyc(); cyc();
    clr = 1'b0;
    chk_en = 1'b1;

    // inactive lane ignored
    set_lane(0, 200, 0); cyc();
    chk("t1_destroy", 32'(bus.destroy), 32'd0);
    chk("t1_lives", 32'(lives), 32'd3);
    chk("t1_game_over", 32'(game_over), 32'd0);

    // single hit, then mask
    set_lane(2, 205, 395); cyc();
    chk("t2_destroy", 32'(bus.destroy), 32'b00100);
    chk("t2_hit", 32'(player_hit), 32'd1);
    chk("t2_lives", 32'(lives), 32'd2);
    chk("t2_invuln", 32'(invulnerable), 32'd1);
    cyc();
    chk("t2_mask", 32'(bus.destroy), 32'd0);
    chk("t2_hit_once", 32'(player_hit), 32'd0);
    // restart with a live in-box shot still on the bus
    play = 1'b0; cyc(); play = 1'b1;
    chk("t2_restart_destroy", 32'(bus.destroy), 32'd0);
    chk("t2_restart_lives", 32'(lives), 32'd3);
    clear_lanes();

    // simultaneous hits
    set_lane(0, 200, 400); set_lane(1, 192, 384); set_lane(4, 208, 390); cyc();
    chk("t3_destroy", 32'(bus.destroy), 32'b10011);
    chk("t3_lives", 32'(lives), 32'd2);
    chk("t3_hit", 32'(player_hit), 32'd1);
    clear_lanes(); cyc();
    chk("t3_hit_single", 32'(player_hit), 32'd0);

    // invulnerable hit, then expiry
    set_lane(3, 199, 396); cyc();
    chk("t4_destroy", 32'(bus.destroy), 32'b01000);
    chk("t4_lives", 32'(lives), 32'd2);
    chk("t4_hit", 32'(player_hit), 32'd0);
    clear_lanes();
    repeat (INV - 3) cyc();
    chk("t4_still_invuln", 32'(invulnerable), 32'd1);
    cyc();
    chk("t4_invuln_end", 32'(invulnerable), 32'd0);
    set_lane(1, 200, 400); cyc();
    chk("t4_lives_after", 32'(lives), 32'd1);
    clear_lanes();

    // run out of lives
    restart();
    for (int h = 0; h < 3; h++) begin
      set_lane(0, 200, 400); cyc();
      chk("t5_lives", 32'(lives), 32'(2 - h));
      clear_lanes();
      repeat (INV) cyc();
    end
    chk("t5_game_over", 32'(game_over), 32'd1);
    set_lane(0, 200, 400); cyc();
    chk("t5_dead_destroy", 32'(bus.destroy), 32'd0);
    cyc();
    chk("t5_dead_destroy2", 32'(bus.destroy), 32'd0);
    play = 1'b0; cyc(); play = 1'b1;
    chk("t5_restart_lives", 32'(lives), 32'd3);
    chk("t5_restart_go", 32'(game_over), 32'd0);
    clear_lanes();

    // boundaries near the top of the screen
    px = 100; py = 10;
    for (int y = 0; y <= 10; y++) begin
      for (int k = 0; k < 4; k++) begin
        int off;
        off = (k == 0) ? 8 : (k == 1) ? 9 : (k == 2) ? -8 : -9;
        clear_lanes(); restart();
        set_lane(0, 100 + off, y); cyc();
        chk("t6_edge", 32'(bus.destroy[0]), 32'((off == 8 || off == -8) && y != 0));
      end
    end
    clear_lanes(); restart();
    set_lane(0, 100, 500); cyc();
    chk("t6_no_wrap", 32'(bus.destroy), 32'd0);
    clear_lanes(); px = 600; py = 300; restart();
    set_lane(4, 608, 290); cyc();
    chk("t6_lane4_wide_x", 32'(bus.destroy), 32'b10000);
    clear_lanes();

`ifdef PLAYER_BLINK_EN
    restart();
    set_lane(0, 600, 300); cyc();
    chk("blink_entry", 32'(player_visible), 32'd0);
    clear_lanes();
    repeat (BLINK - 1) cyc();
    chk("blink_hold", 32'(player_visible), 32'd0);
    cyc();
    chk("blink_toggle", 32'(player_visible), 32'd1);
    repeat (BLINK) cyc();
    chk("blink_toggle2", 32'(player_visible), 32'd0);
`endif

    // randomized play
    for (int c = 0; c < 4000; c++) begin
      clr  = ($urandom_range(0, 499) == 0);
      play = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 1) == 1) begin
        px = int'($urandom_range(0, 600));
        py = int'($urandom_range(0, 520));
        for (int i = 0; i < 5; i++) begin
          int r, xmax, xv, yv;
          r = int'($urandom_range(0, 3));
          xmax = (i == 4) ? 1023 : 511;
          if (r == 0) begin
            xv = int'($urandom_range(0, 511)); yv = 0;
          end else if (r == 1) begin
            xv = int'($urandom_range(0, 511)); yv = int'($urandom_range(0, 511));
          end else begin
            xv = px + int'($urandom_range(0, 20)) - 10;
            yv = py + 2 - int'($urandom_range(0, 20));
          end
          if (xv < 0) xv = 0;
          if (xv > xmax) xv = xmax;
          if (yv < 0) yv = 0;
          if (yv > 511) yv = 511;
          set_lane(i, xv, yv);
        end
      end
      cyc();
    end

    clr = 1'b0; play = 1'b1; clear_lanes();
    cyc(); cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
